// File: rtl/snoop_bus_if.sv
// Bus bundle between the snoop bus controller and the per-cache emitters/snoopers.
// Handshake: a cache raises req[i] with req_op[2i+1:2i] and holds it until done[i] pulses for one cycle.
interface snoop_bus_if;
   logic [3:0] req;
   logic [7:0] req_op;
   logic [3:0] grant;
   logic       snoop_valid;
   logic [1:0] snoop_bus;
   logic [1:0] snoop_src;
   logic [3:0] snoop_shared;
   logic [3:0] snoop_abort;
   logic       mem_rd;
   logic       mem_wr;
   logic [3:0] done;
   logic       shared_out;
   logic       proto_err;
   logic [2:0] fsm_state;

   modport master (
      input  req, req_op, snoop_shared, snoop_abort,
      output grant, snoop_valid, snoop_bus, snoop_src, mem_rd, mem_wr,
             done, shared_out, proto_err, fsm_state
   );

   modport slave (
      output req, req_op, snoop_shared, snoop_abort,
      input  grant, snoop_valid, snoop_bus, snoop_src, mem_rd, mem_wr,
             done, shared_out, proto_err, fsm_state
   );
endinterface

// File: rtl/snoop_bus_controller.sv
// Round-robin MESI snoop bus controller: arbitrates, broadcasts one snoop,
// then completes via memory fill, owner writeback or directly (invalidate).
module snoop_bus_controller #(
   parameter int N_CACHES    = 4,
   parameter int MEM_LATENCY = 3
) (
   input  logic         clock,
   input  logic         reset,
   snoop_bus_if.master  bus
);

   typedef enum logic [2:0] {S_IDLE, S_SNOOP, S_MEM, S_WB, S_DONE} state_t;

   state_t     state, state_n;
   logic [1:0] winner, winner_n, op, op_n, rr, rr_n;
   logic       sh, sh_n, perr, perr_n;
   logic [3:0] cnt, cnt_n;
   logic [3:0] grant_q, grant_n, done_q, done_n;
   logic       snoop_valid_q, snoop_valid_n, mem_rd_q, mem_rd_n;
   logic       mem_wr_q, mem_wr_n, shared_q, shared_n;
   logic [1:0] bus_q, bus_n, src_q, src_n;
   logic       found;
   logic [1:0] pick, idx;
   logic [3:0] masked_sh, masked_ab;

   function automatic logic [3:0] onehot(input logic [1:0] i);
      return 4'b0001 << i;
   endfunction

   always_comb begin
      state_n       = state;
      winner_n      = winner;
      op_n          = op;
      sh_n          = sh;
      cnt_n         = cnt;
      rr_n          = rr;
      perr_n        = perr;
      snoop_valid_n = 1'b0;
      bus_n         = 2'b00;
      src_n         = 2'b00;
      mem_rd_n      = 1'b0;
      mem_wr_n      = 1'b0;
      done_n        = 4'b0000;
      shared_n      = 1'b0;
      found         = 1'b0;
      pick          = rr;
      idx           = rr;
      // The requester never answers its own snoop.
      masked_sh     = bus.snoop_shared & ~onehot(winner);
      masked_ab     = bus.snoop_abort & ~onehot(winner);

      for (int i = 0; i < N_CACHES; i++) begin
         idx = rr + 2'(i);
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end

      case (state)
         S_IDLE: begin
            if (found) begin
               winner_n = pick;
               op_n     = bus.req_op[{pick, 1'b0} +: 2];
               sh_n     = 1'b0;
               if (op_n == 2'b00) begin
                  state_n = S_DONE;
                  done_n  = onehot(pick);
               end else begin
                  state_n       = S_SNOOP;
                  snoop_valid_n = 1'b1;
                  bus_n         = op_n;
                  src_n         = pick;
               end
            end
         end
         S_SNOOP: begin
            sh_n   = |masked_sh;
            perr_n = perr | (|(masked_ab & (masked_ab - 4'd1)));
            if (op == 2'b11) begin
               state_n = S_DONE;
               done_n  = onehot(winner);
            end else if (|masked_ab) begin
               state_n  = S_WB;
               mem_wr_n = 1'b1;
            end else begin
               state_n  = S_MEM;
               mem_rd_n = 1'b1;
               cnt_n    = 4'(MEM_LATENCY - 1);
            end
         end
         S_MEM: begin
            if (cnt == 4'd0) begin
               state_n  = S_DONE;
               done_n   = onehot(winner);
               shared_n = sh;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         S_WB: begin
            state_n  = S_DONE;
            done_n   = onehot(winner);
            shared_n = sh;
         end
         S_DONE: begin
            state_n = S_IDLE;
            rr_n    = winner + 2'd1;
         end
         default: state_n = S_IDLE;
      endcase

      // Grant is held from SNOOP through DONE and dropped on the way back to IDLE.
      grant_n = (state_n == S_IDLE) ? 4'b0000 : onehot(winner_n);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= S_IDLE;
         winner        <= 2'b00;
         op            <= 2'b00;
         sh            <= 1'b0;
         cnt           <= 4'd0;
         rr            <= 2'b00;
         perr          <= 1'b0;
         grant_q       <= 4'b0000;
         snoop_valid_q <= 1'b0;
         bus_q         <= 2'b00;
         src_q         <= 2'b00;
         mem_rd_q      <= 1'b0;
         mem_wr_q      <= 1'b0;
         done_q        <= 4'b0000;
         shared_q      <= 1'b0;
      end else begin
         state         <= state_n;
         winner        <= winner_n;
         op            <= op_n;
         sh            <= sh_n;
         cnt           <= cnt_n;
         rr            <= rr_n;
         perr          <= perr_n;
         grant_q       <= grant_n;
         snoop_valid_q <= snoop_valid_n;
         bus_q         <= bus_n;
         src_q         <= src_n;
         mem_rd_q      <= mem_rd_n;
         mem_wr_q      <= mem_wr_n;
         done_q        <= done_n;
         shared_q      <= shared_n;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.snoop_valid = snoop_valid_q;
   assign bus.snoop_bus   = bus_q;
   assign bus.snoop_src   = src_q;
   assign bus.mem_rd      = mem_rd_q;
   assign bus.mem_wr      = mem_wr_q;
   assign bus.done        = done_q;
   assign bus.shared_out  = shared_q;
   assign bus.proto_err   = perr;
   assign bus.fsm_state   = state;

endmodule

// File: tb/tb_snoop_bus_controller.sv
// Directed bench for snoop_bus_controller: vector table for single transactions,
// hand sequences for round-robin, mid-transaction reset and sticky proto_err.
module tb_snoop_bus_controller;

   logic clock = 1'b0;
   logic reset = 1'b1;

   snoop_bus_if bus();

   snoop_bus_controller #(.N_CACHES(4), .MEM_LATENCY(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0] req;
      logic [7:0] op;
      logic [3:0] sh;
      logic [3:0] ab;
      logic [3:0] e_done;
      logic       e_shared;
      int         e_lat;
      int         e_rd;
      int         e_wr;
      int         e_sv;
      logic [1:0] e_bus;
      logic [1:0] e_src;
   } vec_t;

   typedef struct {
      int lat;
      int done;
      int shared;
      int nrd;
      int nwr;
      int nsv;
      int sbus;
      int src;
      int grant1;
      int grant_done;
      int perr;
      int leak;
   } obs_t;

   vec_t vecs[11];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int all_outs();
      return int'({bus.grant, bus.snoop_valid, bus.snoop_bus, bus.snoop_src, bus.mem_rd,
                   bus.mem_wr, bus.done, bus.shared_out, bus.proto_err, bus.fsm_state});
   endfunction

   task automatic do_reset(input string name);
      reset            = 1'b1;
      bus.req          = 4'b0;
      bus.req_op       = 8'h00;
      bus.snoop_shared = 4'b0;
      bus.snoop_abort  = 4'b0;
      repeat (3) tick();
      check({name, "_outs"}, all_outs(), 0);
      reset = 1'b0;
   endtask

   task automatic run_txn(input vec_t v, output obs_t o);
      o = '{default: 0};
      bus.req = 4'b0;
      tick();
      bus.req          = v.req;
      bus.req_op       = v.op;
      bus.snoop_shared = v.sh;
      bus.snoop_abort  = v.ab;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (c == 1) o.grant1 = int'(bus.grant);
         if (bus.snoop_valid) begin
            o.nsv++;
            o.sbus = int'(bus.snoop_bus);
            o.src  = int'(bus.snoop_src);
         end else if (bus.snoop_bus != 2'b00) begin
            o.leak++;
         end
         if (bus.mem_rd) o.nrd++;
         if (bus.mem_wr) o.nwr++;
         if (bus.done != 4'b0) begin
            o.lat        = c;
            o.done       = int'(bus.done);
            o.shared     = int'(bus.shared_out);
            o.perr       = int'(bus.proto_err);
            o.grant_done = int'(bus.grant);
            break;
         end
      end
      bus.req          = 4'b0;
      bus.snoop_shared = 4'b0;
      bus.snoop_abort  = 4'b0;
   endtask

   initial begin
      obs_t       o;
      vec_t       v;
      logic [3:0] dseq[5];
      int         dcyc[5];
      int         k;
      logic [3:0] seen;

      //           req      op     sh       ab       done     shr   lat rd wr sv bus    src
      vecs[0]  = '{4'b0001, 8'h01, 4'b0000, 4'b0000, 4'b0001, 1'b0, 5, 1, 0, 1, 2'b01, 2'd0};
      vecs[1]  = '{4'b0001, 8'h01, 4'b0100, 4'b0000, 4'b0001, 1'b1, 5, 1, 0, 1, 2'b01, 2'd0};
      vecs[2]  = '{4'b0001, 8'h01, 4'b0001, 4'b0000, 4'b0001, 1'b0, 5, 1, 0, 1, 2'b01, 2'd0};
      vecs[3]  = '{4'b0010, 8'h08, 4'b0000, 4'b1000, 4'b0010, 1'b0, 3, 0, 1, 1, 2'b10, 2'd1};
      vecs[4]  = '{4'b0100, 8'h10, 4'b1000, 4'b1000, 4'b0100, 1'b1, 3, 0, 1, 1, 2'b01, 2'd2};
      vecs[5]  = '{4'b1000, 8'h80, 4'b1000, 4'b1000, 4'b1000, 1'b0, 5, 1, 0, 1, 2'b10, 2'd3};
      vecs[6]  = '{4'b0010, 8'h0C, 4'b0001, 4'b0001, 4'b0010, 1'b0, 2, 0, 0, 1, 2'b11, 2'd1};
      vecs[7]  = '{4'b0100, 8'h00, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1, 0, 0, 0, 2'b00, 2'd0};
      vecs[8]  = '{4'b0011, 8'h05, 4'b0000, 4'b0000, 4'b0001, 1'b0, 5, 1, 0, 1, 2'b01, 2'd0};
      vecs[9]  = '{4'b0011, 8'h05, 4'b0100, 4'b0000, 4'b0010, 1'b1, 5, 1, 0, 1, 2'b01, 2'd1};
      vecs[10] = '{4'b0001, 8'h00, 4'b0010, 4'b0000, 4'b0001, 1'b0, 1, 0, 0, 0, 2'b00, 2'd0};

      do_reset("reset0");

      for (int i = 0; i < 11; i++) begin
         run_txn(vecs[i], o);
         check($sformatf("v%0d_lat", i), o.lat, vecs[i].e_lat);
         check($sformatf("v%0d_done", i), o.done, int'(vecs[i].e_done));
         check($sformatf("v%0d_shared", i), o.shared, int'(vecs[i].e_shared));
         check($sformatf("v%0d_mem_rd", i), o.nrd, vecs[i].e_rd);
         check($sformatf("v%0d_mem_wr", i), o.nwr, vecs[i].e_wr);
         check($sformatf("v%0d_snoop_cnt", i), o.nsv, vecs[i].e_sv);
         check($sformatf("v%0d_grant_c1", i), o.grant1, int'(vecs[i].e_done));
         check($sformatf("v%0d_grant_done", i), o.grant_done, int'(vecs[i].e_done));
         check($sformatf("v%0d_proto_err", i), o.perr, 0);
         check($sformatf("v%0d_bus_idle", i), o.leak, 0);
         if (vecs[i].e_sv != 0) begin
            check($sformatf("v%0d_snoop_bus", i), o.sbus, int'(vecs[i].e_bus));
            check($sformatf("v%0d_snoop_src", i), o.src, int'(vecs[i].e_src));
         end
      end

      // All four invalidating continuously: strict rotation, 3 cycles apart, then wrap to 0.
      do_reset("reset_t4");
      bus.req_op = 8'hFF;
      bus.req    = 4'b1111;
      k = 0;
      for (int i = 0; i < 5; i++) begin
         dseq[i] = 4'b0;
         dcyc[i] = 0;
      end
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (bus.done != 4'b0) begin
            dseq[k] = bus.done;
            dcyc[k] = c;
            k++;
            if (k == 5) break;
         end
      end
      bus.req = 4'b0;
      check("t4_count", k, 5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t4_done%0d", i), int'(dseq[i]), int'(4'b0001 << (i % 4)));
         check($sformatf("t4_cyc%0d", i), dcyc[i], 2 + 3 * i);
      end

      // Reset in the second MEM cycle aborts the fill; request is re-served afterwards.
      tick();
      bus.req_op = 8'h10;
      bus.req    = 4'b0100;
      seen       = 4'b0;
      for (int c = 1; c <= 3; c++) begin
         tick();
         seen |= bus.done;
      end
      check("t5_state_mem", int'(bus.fsm_state), 2);
      reset = 1'b1;
      tick();
      seen |= bus.done;
      check("t5_no_done", int'(seen), 0);
      check("t5_reset_outs", all_outs(), 0);
      reset = 1'b0;
      k = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (bus.done != 4'b0) begin
            k = c;
            check("t5_redone", int'(bus.done), 4);
            break;
         end
      end
      check("t5_relat", k, 5);
      bus.req = 4'b0;

      // Two foreign abort responses: writeback still completes, proto_err latches.
      v = '{4'b0001, 8'h02, 4'b0000, 4'b0110, 4'b0001, 1'b0, 3, 0, 1, 1, 2'b10, 2'd0};
      run_txn(v, o);
      check("t6_lat", o.lat, 3);
      check("t6_done", o.done, 1);
      check("t6_mem_wr", o.nwr, 1);
      check("t6_mem_rd", o.nrd, 0);
      check("t6_proto_err", o.perr, 1);
      run_txn(vecs[0], o);
      check("t6_sticky_lat", o.lat, 5);
      check("t6_sticky_err", o.perr, 1);
      reset = 1'b1;
      tick();
      check("t6_err_cleared", int'(bus.proto_err), 0);
      reset = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
